// File: rtl/puf_response_collector_pkg.sv
// Shared definitions for the PDL PUF response collector: FSM encoding,
// default geometry and width helpers.
package puf_response_collector_pkg;

  localparam int DEF_RESP_BITS     = 64;
  localparam int DEF_NUM_EVALS     = 15;
  localparam int DEF_SETTLE_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DECIDE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

  // Counter width for values 0..count-1, never narrower than one bit.
  function automatic int cnt_width(input int count);
    return (count > 32'sd1) ? clog2(count) : 32'sd1;
  endfunction

endpackage

// File: rtl/puf_response_collector_voter.sv
// Accumulates the ones seen across the evaluations of one bit and reports
// the majority vote and whether the evaluations disagreed.
module puf_majority_voter
  import puf_response_collector_pkg::*;
#(
  parameter int NUM_EVALS = DEF_NUM_EVALS
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic sample_en,
  input  logic bit_in,
  output logic vote,
  output logic unstable
);

  localparam int ONES_W = clog2(NUM_EVALS + 1);

  logic [ONES_W-1:0] ones_cnt_r;

  // ones counter: cleared per bit, bumped once per sampled evaluation
  always_ff @(posedge clk) begin
    if (reset) begin
      ones_cnt_r <= ONES_W'(0);
    end else if (clear) begin
      ones_cnt_r <= ONES_W'(0);
    end else if (sample_en) begin
      ones_cnt_r <= ones_cnt_r + ONES_W'(bit_in);
    end else begin
      ones_cnt_r <= ones_cnt_r;
    end
  end

  // vote and stability flag derived purely from the stored count
  always_comb begin
    vote     = (ones_cnt_r > ONES_W'(NUM_EVALS / 2));
    unstable = (ones_cnt_r != ONES_W'(0)) && (ones_cnt_r != ONES_W'(NUM_EVALS));
  end

endmodule

// File: rtl/puf_response_collector.sv
// Launches the PDL lines, samples and majority-votes each response bit, and
// hands the assembled word to the host over a valid/ready handshake.
module puf_response_collector
  import puf_response_collector_pkg::*;
#(
  parameter int RESP_BITS     = DEF_RESP_BITS,
  parameter int NUM_EVALS     = DEF_NUM_EVALS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic                              busy,
  output logic                              puf_trigger,
  input  logic                              xor_response,
  output logic                              challenge_advance,
  output logic [RESP_BITS-1:0]              resp_word,
  output logic [clog2(RESP_BITS+1)-1:0]     unstable_cnt,
  output logic                              resp_valid,
  input  logic                              resp_ready
);

  localparam int BIT_W    = cnt_width(RESP_BITS);
  localparam int EVAL_W   = cnt_width(NUM_EVALS);
  localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);
  localparam int UNST_W   = clog2(RESP_BITS + 1);

  if (RESP_BITS < 1) begin : g_chk_resp_bits
    $error("RESP_BITS must be at least 1");
  end
  if ((NUM_EVALS < 1) || ((NUM_EVALS % 2) == 0)) begin : g_chk_num_evals
    $error("NUM_EVALS must be odd and at least 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_chk_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  state_e                state_r;
  logic [BIT_W-1:0]      bit_idx_r;
  logic [EVAL_W-1:0]     eval_cnt_r;
  logic [SETTLE_W-1:0]   settle_cnt_r;
  logic [RESP_BITS-1:0]  resp_word_r;
  logic [UNST_W-1:0]     unstable_cnt_r;
  logic                  busy_r;
  logic                  puf_trigger_r;
  logic                  challenge_advance_r;
  logic                  resp_valid_r;
  logic                  voter_clear_s;
  logic                  voter_sample_s;
  logic                  vote_s;
  logic                  unstable_s;

  // voter control: clear on word start and after each decision
  always_comb begin
    voter_clear_s  = 1'b0;
    voter_sample_s = 1'b0;
    case (state_r)
      ST_IDLE:   voter_clear_s  = start;
      ST_SAMPLE: voter_sample_s = 1'b1;
      ST_DECIDE: voter_clear_s  = 1'b1;
      default: begin
        voter_clear_s  = 1'b0;
        voter_sample_s = 1'b0;
      end
    endcase
  end

  puf_majority_voter #(
    .NUM_EVALS (NUM_EVALS)
  ) u_voter (
    .clk       (clk),
    .reset     (reset),
    .clear     (voter_clear_s),
    .sample_en (voter_sample_s),
    .bit_in    (xor_response),
    .vote      (vote_s),
    .unstable  (unstable_s)
  );

  // main FSM; strobes are set on entry so they line up with their state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r             <= ST_IDLE;
      bit_idx_r           <= BIT_W'(0);
      eval_cnt_r          <= EVAL_W'(0);
      settle_cnt_r        <= SETTLE_W'(0);
      resp_word_r         <= RESP_BITS'(0);
      unstable_cnt_r      <= UNST_W'(0);
      busy_r              <= 1'b0;
      puf_trigger_r       <= 1'b0;
      challenge_advance_r <= 1'b0;
      resp_valid_r        <= 1'b0;
    end else begin
      puf_trigger_r       <= 1'b0;
      challenge_advance_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r        <= ST_LAUNCH;
            busy_r         <= 1'b1;
            puf_trigger_r  <= 1'b1;
            resp_word_r    <= RESP_BITS'(0);
            unstable_cnt_r <= UNST_W'(0);
            bit_idx_r      <= BIT_W'(0);
            eval_cnt_r     <= EVAL_W'(0);
          end
        end
        ST_LAUNCH: begin
          state_r      <= ST_SETTLE;
          settle_cnt_r <= SETTLE_W'(0);
        end
        ST_SETTLE: begin
          if (settle_cnt_r == SETTLE_W'(SETTLE_CYCLES - 1)) begin
            state_r <= ST_SAMPLE;
          end else begin
            settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (eval_cnt_r == EVAL_W'(NUM_EVALS - 1)) begin
            state_r             <= ST_DECIDE;
            challenge_advance_r <= 1'b1;
          end else begin
            eval_cnt_r    <= eval_cnt_r + EVAL_W'(1);
            state_r       <= ST_LAUNCH;
            puf_trigger_r <= 1'b1;
          end
        end
        ST_DECIDE: begin
          resp_word_r[bit_idx_r] <= vote_s;
          if (unstable_s) begin
            unstable_cnt_r <= unstable_cnt_r + UNST_W'(1);
          end
          eval_cnt_r <= EVAL_W'(0);
          if (bit_idx_r == BIT_W'(RESP_BITS - 1)) begin
            state_r      <= ST_DONE;
            resp_valid_r <= 1'b1;
          end else begin
            bit_idx_r     <= bit_idx_r + BIT_W'(1);
            state_r       <= ST_LAUNCH;
            puf_trigger_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            state_r      <= ST_IDLE;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy              = busy_r;
  assign puf_trigger       = puf_trigger_r;
  assign challenge_advance = challenge_advance_r;
  assign resp_word         = resp_word_r;
  assign unstable_cnt      = unstable_cnt_r;
  assign resp_valid        = resp_valid_r;

endmodule

// File: tb/tb_puf_response_collector.sv
// Directed bench for puf_response_collector with RESP_BITS=4, NUM_EVALS=3,
// SETTLE_CYCLES=2 (13 cycles per bit, resp_valid in cycle 53).
module tb_puf_response_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       puf_trigger;
  logic       xor_response;
  logic       challenge_advance;
  logic [3:0] resp_word;
  logic [2:0] unstable_cnt;
  logic       resp_valid;
  logic       resp_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [11:0] pat;   // bit b*3+k = evaluation k of response bit b
    logic [3:0]  word;
    logic [2:0]  unst;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  puf_response_collector #(
    .RESP_BITS     (4),
    .NUM_EVALS     (3),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .busy              (busy),
    .puf_trigger       (puf_trigger),
    .xor_response      (xor_response),
    .challenge_advance (challenge_advance),
    .resp_word         (resp_word),
    .unstable_cnt      (unstable_cnt),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Evaluation value for cycle c of a run; inverted outside SAMPLE cycles so a
  // mistimed sample picks up the wrong value.
  function automatic logic xor_for(input logic [11:0] pat, input int c);
    int rel, b, r, k;
    logic v;
    rel = c - 1;
    if (c < 1 || rel >= 52) return 1'b0;
    b = rel / 13;
    r = rel % 13;
    if (r >= 12) return 1'b0;
    k = r / 4;
    v = pat[b*3 + k];
    return (r % 4 == 3) ? v : ~v;
  endfunction

  // Start a word in cycle 0 and check every strobe through cycle 53 (DONE).
  task automatic run_word(input string tag, input logic [11:0] pat,
                          input logic [3:0] exp_word, input logic [2:0] exp_unst);
    int trig_n, trig_bad, adv_bad, valid_bad, busy_bad;
    int r;
    logic e_trig, e_adv, e_valid;
    trig_n = 0; trig_bad = 0; adv_bad = 0; valid_bad = 0; busy_bad = 0;
    start = 1'b1;
    xor_response = 1'b0;
    step();
    start = 1'b0;
    for (int c = 1; c <= 53; c++) begin
      if (c > 1) step();
      xor_response = xor_for(pat, c);
      r       = (c - 1) % 13;
      e_trig  = (c <= 52) && (r < 12) && (r % 4 == 0);
      e_adv   = (c <= 52) && (r == 12);
      e_valid = (c == 53);
      if (puf_trigger === 1'b1) trig_n++;
      if (puf_trigger !== e_trig) trig_bad++;
      if (challenge_advance !== e_adv) adv_bad++;
      if (resp_valid !== e_valid) valid_bad++;
      if (busy !== 1'b1) busy_bad++;
    end
    check({tag, "_trig_count"}, trig_n, 12);
    check({tag, "_trig_timing_errs"}, trig_bad, 0);
    check({tag, "_adv_timing_errs"}, adv_bad, 0);
    check({tag, "_valid_timing_errs"}, valid_bad, 0);
    check({tag, "_busy_errs"}, busy_bad, 0);
    check({tag, "_word"}, resp_word, exp_word);
    check({tag, "_unstable"}, unstable_cnt, exp_unst);
  endtask

  initial begin
    int bad;
    vecs[0] = '{pat: 12'hFFF, word: 4'hF, unst: 3'd0};
    vecs[1] = '{pat: 12'hE23, word: 4'h9, unst: 3'd2};
    vecs[2] = '{pat: 12'h000, word: 4'h0, unst: 3'd0};
    vecs[3] = '{pat: 12'h54E, word: 4'h5, unst: 3'd4};
    vecs[4] = '{pat: 12'h007, word: 4'h1, unst: 3'd0};

    // Reset state
    reset = 1'b1; start = 1'b0; xor_response = 1'b0; resp_ready = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_trig", puf_trigger, 0);
    check("rst_adv", challenge_advance, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_word", resp_word, 0);
    check("rst_unst", unstable_cnt, 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      xor_response = ~xor_response;
      step();
      if (busy !== 1'b0 || puf_trigger !== 1'b0 || resp_valid !== 1'b0 ||
          challenge_advance !== 1'b0) bad++;
    end
    check("idle_xor_toggle_errs", bad, 0);

    // Table-driven words with host always ready
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_word($sformatf("vec%0d", i), vecs[i].pat, vecs[i].word, vecs[i].unst);
      step();
      check($sformatf("vec%0d_idle_busy", i), busy, 0);
      check($sformatf("vec%0d_idle_valid", i), resp_valid, 0);
    end

    // Backpressure with start pulses during DONE
    resp_ready = 1'b0;
    run_word("bp", 12'hE23, 4'h9, 3'd2);
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      start = (j % 2 == 0);
      step();
      if (resp_valid !== 1'b1 || resp_word !== 4'h9 || unstable_cnt !== 3'd2 ||
          busy !== 1'b1 || puf_trigger !== 1'b0) bad++;
    end
    check("bp_hold_errs", bad, 0);
    start = 1'b1;
    resp_ready = 1'b1;
    step();
    start = 1'b0;
    resp_ready = 1'b0;
    check("bp_hs_busy", busy, 0);
    check("bp_hs_valid", resp_valid, 0);
    step();
    check("bp_no_restart_busy", busy, 0);
    check("bp_no_restart_trig", puf_trigger, 0);
    check("bp_word_hold", resp_word, 4'h9);

    // Reset in cycle 20 of a run
    start = 1'b1;
    xor_response = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    reset = 1'b1;
    step();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_trig", puf_trigger, 0);
    check("mid_rst_adv", challenge_advance, 0);
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_word", resp_word, 0);
    check("mid_rst_unst", unstable_cnt, 0);
    reset = 1'b0;
    step();
    check("post_rst_quiet", {busy, puf_trigger, challenge_advance}, 0);
    resp_ready = 1'b1;
    run_word("post_rst", 12'h54E, 4'h5, 3'd4);
    step();
    check("post_rst_idle", busy, 0);

    // start held high continuously
    resp_ready = 1'b0;
    start = 1'b1;
    xor_response = 1'b1;
    bad = 0;
    step();
    for (int c = 2; c <= 53; c++) begin
      step();
      if (c < 53 && resp_valid !== 1'b0) bad++;
    end
    check("cont_early_valid_errs", bad, 0);
    check("cont_valid53", resp_valid, 1);
    check("cont_word", resp_word, 4'hF);
    bad = 0;
    for (int c = 54; c <= 56; c++) begin
      step();
      if (resp_valid !== 1'b1 || puf_trigger !== 1'b0) bad++;
    end
    check("cont_done_hold_errs", bad, 0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("cont_hs_busy", busy, 0);
    check("cont_hs_valid", resp_valid, 0);
    step();
    check("cont_restart_trig", puf_trigger, 1);
    check("cont_restart_busy", busy, 1);
    start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
